// File: rtl/skidbuf_chain.sv
// Chain of STAGES skid-buffer slices on a valid/ready stream, with synchronous
// flush, live occupancy count and a sticky high-watermark.
module skidbuf_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CW     = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    max_count
);

  // Encoding keeps bit 0 as the output-valid flag and bit 1 as the skid-valid flag.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } stage_e;

  stage_e           state_q [STAGES];
  stage_e           state_d [STAGES];
  logic [WIDTH-1:0] od_q    [STAGES];
  logic [WIDTH-1:0] sd_q    [STAGES];
  logic [WIDTH-1:0] din     [STAGES];

  logic [STAGES-1:0] ov, sv, in_fire, out_fire, ld_od, od_from_sd, ld_sd;
  logic [CW-1:0]     count_q, count_d, max_q, max_d;

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      ov[i] = (state_q[i] != EMPTY);
      sv[i] = (state_q[i] == FULL);
    end
  end

  assign s_ready   = !sv[0] && !flush;
  assign m_valid   = ov[STAGES-1];
  assign m_data    = od_q[STAGES-1];
  assign count     = count_q;
  assign max_count = max_q;

  always_comb begin
    out_fire[STAGES-1] = ov[STAGES-1] && m_ready;
    for (int unsigned i = 0; i + 1 < STAGES; i++) begin
      out_fire[i] = ov[i] && !sv[i+1];
    end
    in_fire[0] = s_valid && s_ready;
    din[0]     = s_data;
    for (int unsigned i = 1; i < STAGES; i++) begin
      in_fire[i] = out_fire[i-1];
      din[i]     = od_q[i-1];
    end

    for (int unsigned i = 0; i < STAGES; i++) begin
      state_d[i]    = state_q[i];
      ld_od[i]      = 1'b0;
      od_from_sd[i] = 1'b0;
      ld_sd[i]      = 1'b0;
      unique case (state_q[i])
        EMPTY: begin
          if (in_fire[i]) begin
            state_d[i] = BUSY;
            ld_od[i]   = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire[i] && !out_fire[i]) begin
            state_d[i] = FULL;
            ld_sd[i]   = 1'b1;
          end else if (in_fire[i] && out_fire[i]) begin
            ld_od[i]   = 1'b1;
          end else if (out_fire[i]) begin
            state_d[i] = EMPTY;
          end
        end
        FULL: begin
          if (out_fire[i]) begin
            state_d[i]    = BUSY;
            ld_od[i]      = 1'b1;
            od_from_sd[i] = 1'b1;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
      if (flush) state_d[i] = EMPTY;
    end

    if (flush) count_d = '0;
    else       count_d = count_q + CW'(in_fire[0]) - CW'(out_fire[STAGES-1]);
    max_d = (count_d > max_q) ? count_d : max_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < STAGES; i++) state_q[i] <= EMPTY;
      count_q <= '0;
      max_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) state_q[i] <= state_d[i];
      count_q <= count_d;
      max_q   <= max_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (ld_sd[i]) sd_q[i] <= din[i];
      if (ld_od[i]) od_q[i] <= od_from_sd[i] ? sd_q[i] : din[i];
    end
  end

endmodule

// File: tb/tb_skidbuf_chain.sv
// Directed bench for skidbuf_chain: a 3-stage instance for the main scenarios
// plus a 1-stage instance for the single-slice corner.
module tb_skidbuf_chain;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, s_valid, m_ready, s_ready, m_valid;
  logic [7:0] s_data, m_data;
  logic [2:0] count, max_count;

  logic       flush1, s_valid1, m_ready1, s_ready1, m_valid1;
  logic [7:0] s_data1, m_data1;
  logic [1:0] count1, max_count1;

  skidbuf_chain #(.WIDTH(8), .STAGES(3)) dut (
    .clk(clk), .reset_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .max_count(max_count)
  );

  skidbuf_chain #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .flush(flush1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
    .count(count1), .max_count(max_count1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [7:0] sb[$];
  logic [7:0] exp_d;

  initial begin
    int acc, pushed, popped, cyc, seen;
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    flush1 = 1'b0; s_valid1 = 1'b0; m_ready1 = 1'b0; s_data1 = '0;

    // Reset values
    #2;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_max", max_count, 0);
    chk("rst1_s_ready", s_ready1, 1);
    nxt();
    rst_n = 1'b1;

    // 1. Free flow: 16 items back-to-back, first out in cycle 3
    for (int c = 0; c < 20; c++) begin
      s_valid = (c < 16);
      s_data  = 8'(c);
      m_ready = 1'b1;
      smp();
      if (c < 16) chk("t1_s_ready", s_ready, 1);
      chk("t1_m_valid", m_valid, 32'(c >= 3 && c <= 18));
      if (c >= 3 && c <= 18) chk("t1_m_data", m_data, 32'(c - 3));
      chk("t1_count", count, (c <= 16) ? ((c < 3) ? c : 3) : 19 - c);
      nxt();
    end
    chk("t1_max", max_count, 3);

    // 2. Fill under stall, then drain
    acc = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h20 + acc);
      smp();
      if (s_ready) acc++;
      nxt();
    end
    s_valid = 1'b0;
    smp();
    chk("t2_accepted", acc, 6);
    chk("t2_s_ready", s_ready, 0);
    chk("t2_count", count, 6);
    chk("t2_max", max_count, 6);
    nxt();
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk("t2_drain_valid", m_valid, 1);
      chk("t2_drain_data", m_data, 32'(8'h20 + k));
      nxt();
    end
    smp();
    chk("t2_empty_valid", m_valid, 0);
    chk("t2_empty_count", count, 0);
    chk("t2_s_ready_back", s_ready, 1);
    nxt();

    // 3. Random handshake against a scoreboard
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 1000 && cyc < 20000) begin
      s_valid = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      smp();
      chk("t3_count", count, 32'(pushed - popped));
      chk("t3_range", 32'(count <= 3'd6), 1);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("t3_spurious_valid", m_valid, 0);
        end else begin
          exp_d = sb.pop_front();
          chk("t3_data", m_data, exp_d);
          popped++;
        end
      end
      if (s_valid && s_ready) begin
        sb.push_back(s_data);
        pushed++;
      end
      nxt();
      cyc++;
    end
    chk("t3_delivered", popped, 1000);
    s_valid = 1'b0;
    m_ready = 1'b0;

    // 4. Flush with four items held
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 10 && acc < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + acc);
      smp();
      if (s_ready) acc++;
      nxt();
    end
    s_valid = 1'b0;
    chk("t4_accepted", acc, 4);
    smp();
    chk("t4_count_pre", count, 4);
    nxt();
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hEE;
    smp();
    chk("t4_s_ready_flush", s_ready, 0);
    nxt();
    flush = 1'b0;
    s_valid = 1'b0;
    smp();
    chk("t4_m_valid", m_valid, 0);
    chk("t4_count", count, 0);
    chk("t4_max", max_count, 4);
    nxt();
    s_valid = 1'b1;
    s_data = 8'h77;
    smp();
    chk("t4_s_ready_after", s_ready, 1);
    nxt();
    s_valid = 1'b0;
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (m_valid) begin
        chk("t4_first_after_flush", m_data, 8'h77);
        seen = 1;
        break;
      end
      nxt();
    end
    chk("t4_seen", seen, 1);
    nxt();
    smp();
    chk("t4_no_stale", m_valid, 0);
    nxt();

    // 5. Asynchronous reset with five items held
    m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12 && acc < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h50 + acc);
      smp();
      if (s_ready) acc++;
      nxt();
    end
    s_valid = 1'b0;
    smp();
    chk("t5_count_pre", count, 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", m_valid, 0);
    chk("t5_async_count", count, 0);
    chk("t5_async_max", max_count, 0);
    nxt();
    rst_n = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hA5;
    smp();
    chk("t5_s_ready", s_ready, 1);
    nxt();
    s_valid = 1'b0;
    for (int c = 1; c < 3; c++) begin
      smp();
      chk("t5_latency_gap", m_valid, 0);
      nxt();
    end
    smp();
    chk("t5_valid_c3", m_valid, 1);
    chk("t5_data_c3", m_data, 8'hA5);
    nxt();

    // 6. Single-slice corner
    m_ready1 = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      s_valid1 = 1'b1;
      s_data1  = 8'(8'h10 + acc);
      smp();
      if (s_ready1) acc++;
      nxt();
    end
    smp();
    chk("t6_accepted", acc, 2);
    chk("t6_s_ready", s_ready1, 0);
    chk("t6_count", count1, 2);
    nxt();
    m_ready1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data1 = 8'(8'h10 + acc);
      smp();
      chk("t6_s_ready_drain", s_ready1, 32'(k != 0));
      chk("t6_m_valid", m_valid1, 1);
      chk("t6_m_data", m_data1, 32'(8'h10 + k));
      if (s_ready1) acc++;
      nxt();
    end
    s_valid1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skidbuf_chain.md
# skidbuf_chain

Parametrised chain of `STAGES` skid-buffer register slices carrying `WIDTH`-bit data over a valid/ready handshake. It adds a synchronous flush, a live occupancy count and a sticky high-watermark. It is the generalised successor of the single skid-buffer demo path. It sits between any streaming producer and consumer that need fully registered timing on both data and ready.

## Interface

- `WIDTH`, default 8: data width in bits.
- `STAGES`, default 2: number of chained slices, ≥1. Capacity is 2·`STAGES` entries.
- `CW`, default `$clog2(2*STAGES+1)`: width of the occupancy outputs. Derived; do not override.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous discard of all held data.
- `s_valid` input 1: upstream data valid.
- `s_ready` output 1: upstream ready.
- `s_data` input `WIDTH`: upstream data.
- `m_valid` output 1: downstream data valid.
- `m_ready` input 1: downstream ready.
- `m_data` output `WIDTH`: downstream data.
- `count` output `CW`: entries currently held.
- `max_count` output `CW`: highest `count` value since reset.

## Operation

- Fire definitions: `in_fire = s_valid & s_ready`; `out_fire = m_valid & m_ready`.
- Each stage holds an output register (`ov`, `od`) and a skid register (`sv`, `sd`).
- Stage *i* output feeds stage *i+1* input.
- Stage `ready_in = !sv`. This is registered state only; there is no combinational path from `m_ready` to `s_ready`.
- `s_ready = !sv[0] & !flush`.
- Per-stage state machine:
  - EMPTY (`ov`=0, `sv`=0):
    - in fire → BUSY, `od`←in.
  - BUSY (`ov`=1, `sv`=0):
    - in fire & !out fire → FULL, `sd`←in.
    - in fire & out fire → BUSY, `od`←in.
    - !in fire & out fire → EMPTY.
    - otherwise hold.
  - FULL (`ov`=1, `sv`=1): no input accepted.
    - out fire → BUSY, `od`←`sd`.
    - otherwise hold.
- `m_valid`/`m_data` are the last stage's `ov`/`od`.
- Data registers update only on load; no reset is required on data paths.
- Ordering is strict FIFO. No item is dropped or duplicated except by `flush`.
- `count` is registered: `count ← count + in_fire − out_fire`. Range is 0..2·`STAGES`.
- `max_count ← max(max_count, next count)` each cycle. It is cleared only by reset.
- `flush` high at an edge:
  - All `ov`/`sv` are cleared and `count` becomes 0.
  - `max_count` is kept.
  - Any simultaneous `in_fire` is impossible, because `s_ready` is 0.
  - A simultaneous `out_fire` completes normally this cycle; the downstream side saw valid & ready.
  - `flush` has priority over all stage transitions.

## Timing

- Reset (`reset_n`=0, asynchronous assert, synchronous-safe deassert by the integrator):
  - `m_valid`=0.
  - `s_ready`=1 unless `flush` is high.
  - `count`=0, `max_count`=0.
  - Transfers presented while in reset are lost.
- Latency: an item accepted at the end of cycle 0 appears on `m_valid`/`m_data` in cycle `STAGES` when the chain is empty.
- Throughput: 1 item/cycle sustained with `m_ready`=1. No bubbles at any `STAGES`.
- Backpressure: after `m_ready` falls, the chain absorbs up to 2·`STAGES` items total before `s_ready` falls.
  - `s_ready` falls the cycle after `sv[0]` sets.
  - `s_ready` reasserts the cycle after stage 0 leaves FULL.
- Simultaneous in/out fire at any stage leaves that stage's occupancy unchanged.
- `count` and `max_count` reflect the state after the edge. They are never transiently wrong.

## Test plan

Benches use `WIDTH`=8, `STAGES`=3 unless noted.

1. Free flow: reset, then `m_ready`=1 and `s_valid`=1 with 0x00..0x0F back-to-back → 0x00 on `m_data` in cycle 3. The sequence follows with no gaps. `s_ready` stays 1. `count` settles at 3; `max_count`=3.
2. Fill under stall: `m_ready`=0 with continuous `s_valid` → exactly 6 items are accepted and `s_ready`=0 thereafter, with `count`=6 and `max_count`=6. Raising `m_ready` drains 6 items in order over 6 consecutive cycles. `s_ready` returns to 1; `count`=0.
3. Random handshake: 1000 items with `s_valid` and `m_ready` random at 50% → a scoreboard shows an in-order, lossless, duplicate-free stream. `count` always equals accepted minus delivered and stays within 0..6.
4. Flush: hold `count`=4 with `m_ready`=0, then pulse `flush` for one cycle → `s_ready`=0 during the pulse. Next cycle `m_valid`=0, `count`=0, `max_count`=4. Flushed items never appear on `m_data`.
5. Async reset mid-stream: drop `reset_n` between edges while `count`=5 → `m_valid`, `count` and `max_count` go to 0 immediately without a clock edge. After release, a new item 0xA5 emerges in cycle 3.
6. `STAGES`=1 corner: `m_ready`=0 → 2 items accepted and `s_ready` low. Then `m_ready`=1 with `s_valid`=1 → one item delivered per cycle. `s_ready` is back to 1 the cycle after the skid drains.
